// File: rtl/digit_scan_pkg.sv
// Shared definitions for the seven-segment digit scanner: FSM state encodings
// and display geometry constants.
package digit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/digit_scan_ctrl_slot_timer.sv
// Per-digit slot counter: counts 0..CLK_DIV-1 and flags the blanking gap
// and the last cycle of each slot.
module slot_timer
    import digit_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic clk,
    input  logic clear,
    output logic in_blank,
    output logic slot_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - BLANK_CYC - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign slot_end = (cnt_reg == LAST_CNT);
    // High when the following cycle lies inside the blanking gap; with no gap
    // SHOW_LAST equals LAST_CNT, so this never fires.
    assign in_blank = (cnt_reg >= SHOW_LAST) && !slot_end;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (slot_end) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit scanner: drives the 3-to-8 digit decoder select and
// enable, the active digit's hex nibble, and an end-of-frame pulse.
module digit_scan_ctrl
    import digit_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [2:0]                   num_digits,
    input  logic [DIGITS*NIBBLE_W-1:0]   value,
    output logic [2:0]                   sel,
    output logic                         sel_en,
    output logic [NIBBLE_W-1:0]          nibble,
    output logic                         frame_done
);

    scan_state_t          state_reg, state_next;
    logic [2:0]           sel_reg, last_reg, sel_inc;
    logic                 sel_en_reg, frame_done_reg;
    logic [NIBBLE_W-1:0]  nibble_reg;
    logic                 timer_clear, in_blank, slot_end;
    logic [NIBBLE_W-1:0]  digit_nib [DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign digit_nib[gi] = value[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    // The slot counter sits at zero whenever scanning is stopped, so every
    // start or restart begins a fresh slot.
    assign timer_clear = !rst_n || (state_reg == IDLE) || !run;

    slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk      (clk),
        .clear    (timer_clear),
        .in_blank (in_blank),
        .slot_end (slot_end)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (run) state_next = SHOW;
            end
            SHOW, BLANK: begin
                if (!run)          state_next = IDLE;
                else if (slot_end) state_next = SHOW;
                else if (in_blank) state_next = BLANK;
                else               state_next = SHOW;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_inc = sel_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            last_reg       <= '0;
            sel_en_reg     <= 1'b0;
            nibble_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_en_reg     <= (state_next == SHOW);
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sel_reg    <= '0;
                    last_reg   <= num_digits;
                    nibble_reg <= digit_nib[0];
                end
                default: begin
                    // A stop request outranks a coincident slot end: the
                    // partial frame is dropped without a frame_done pulse.
                    if (!run) begin
                        sel_reg    <= '0;
                        nibble_reg <= digit_nib[0];
                    end else if (slot_end) begin
                        if (sel_reg == last_reg) begin
                            sel_reg        <= '0;
                            nibble_reg     <= digit_nib[0];
                            last_reg       <= num_digits;
                            frame_done_reg <= 1'b1;
                        end else begin
                            sel_reg    <= sel_inc;
                            nibble_reg <= digit_nib[sel_inc];
                        end
                    end
                end
            endcase
        end
    end

    assign sel        = sel_reg;
    assign sel_en     = sel_en_reg;
    assign nibble     = nibble_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: a gapped build (BLANK_CYC=2) and a gapless build
// (BLANK_CYC=0) run side by side against a slot-position reference model.
module tb_digit_scan_ctrl;

    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [2:0]  num_digits;
    logic [31:0] value;

    logic [2:0]  sel_o  [2];
    logic        en_o   [2];
    logic [3:0]  nib_o  [2];
    logic        fd_o   [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: position within the current slot, digit index, frame length.
    bit       m_active [2];
    int       m_off    [2];
    int       m_digit  [2];
    int       m_last   [2];
    bit       m_en     [2];
    bit       m_fd     [2];
    logic [3:0] m_nib  [2];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(2)) dut_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .num_digits (num_digits),
        .value      (value),
        .sel        (sel_o[0]),
        .sel_en     (en_o[0]),
        .nibble     (nib_o[0]),
        .frame_done (fd_o[0])
    );

    digit_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(0)) dut_nogap (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .num_digits (num_digits),
        .value      (value),
        .sel        (sel_o[1]),
        .sel_en     (en_o[1]),
        .nibble     (nib_o[1]),
        .frame_done (fd_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int blank_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic [3:0] digit_of(input logic [31:0] v, input int d);
        logic [31:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    task automatic model_step(input int k);
        m_fd[k] = 1'b0;
        if (!rst_n) begin
            m_active[k] = 1'b0; m_off[k] = 0; m_digit[k] = 0;
            m_en[k] = 1'b0; m_nib[k] = 4'h0;
        end else if (!m_active[k]) begin
            m_off[k] = 0; m_digit[k] = 0;
            m_en[k] = 1'b0;
            if (run) begin
                m_active[k] = 1'b1;
                m_last[k]   = int'(num_digits);
                m_nib[k]    = digit_of(value, 0);
                m_en[k]     = 1'b1;
            end
        end else if (!run) begin
            m_active[k] = 1'b0; m_off[k] = 0; m_digit[k] = 0; m_en[k] = 1'b0;
        end else begin
            m_off[k]++;
            if (m_off[k] == CLK_DIV) begin
                m_off[k] = 0;
                if (m_digit[k] == m_last[k]) begin
                    m_digit[k] = 0;
                    m_last[k]  = int'(num_digits);
                    m_fd[k]    = 1'b1;
                end else begin
                    m_digit[k]++;
                end
                m_nib[k] = digit_of(value, m_digit[k]);
            end
            m_en[k] = (m_off[k] < CLK_DIV - blank_of(k));
        end
    endtask

    // One clock: advance model, then compare every output of both builds.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("sel%0d", k), 32'(sel_o[k]), 32'(m_digit[k]));
            check($sformatf("sel_en%0d", k), 32'(en_o[k]), 32'(m_en[k]));
            check($sformatf("frame_done%0d", k), 32'(fd_o[k]), 32'(m_fd[k]));
            if (m_active[k])
                check($sformatf("nibble%0d", k), 32'(nib_o[k]), 32'(m_nib[k]));
        end
        if (fd_o[0])
            $display("frame_done cycle=%0d last=%0d value=%08h", cyc, m_last[0], value);
    endtask

    task automatic wait_fd(output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fd_o[0]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("fd_timeout", 32'd0, 32'd1);
    endtask

    // Advance until the model is at the given slot offset (and digit, unless -1).
    task automatic wait_model(input int digit, input int off);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (m_active[0] && m_off[0] == off && (digit < 0 || m_digit[0] == digit)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c1, c2, c3, c4, lows, highs, changes;
        logic [2:0] prev;
        rst_n = 1'b0; run = 1'b0; num_digits = 3'd7; value = 32'h76543210;
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_off[k] = 0; m_digit[k] = 0; m_last[k] = 0;
            m_en[k] = 0; m_fd[k] = 0; m_nib[k] = 0;
        end

        // Reset state
        tick();
        check("rst_sel", 32'(sel_o[0]), 32'd0);
        check("rst_en", 32'(en_o[0]), 32'd0);
        check("rst_nib", 32'(nib_o[0]), 32'd0);
        check("rst_fd", 32'(fd_o[0]), 32'd0);
        tick();

        // Full 8-digit scan
        rst_n = 1'b1; run = 1'b1;
        tick();
        check("start_en", 32'(en_o[0]), 32'd1);
        check("start_sel", 32'(sel_o[0]), 32'd0);
        check("start_nib", 32'(nib_o[0]), 32'd0);
        wait_fd(c1);
        wait_fd(c2);
        check("period8", 32'(c2 - c1), 32'd64);

        // Shorter frame, then a mid-frame length change
        for (int i = 0; i < 20; i++) tick();
        num_digits = 3'd2;
        wait_fd(c1);
        wait_fd(c2);
        check("period3", 32'(c2 - c1), 32'd24);
        wait_model(1, 3);
        num_digits = 3'd5;
        wait_fd(c3);
        check("period3_after_change", 32'(c3 - c2), 32'd24);
        wait_fd(c4);
        check("period6", 32'(c4 - c3), 32'd48);

        // Value change during sel=1 SHOW
        num_digits = 3'd7; value = 32'h00000000;
        wait_fd(c1);
        wait_model(1, 2);
        value = 32'hFFFFFFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_digit[0] != 1) break;
            check("nib_hold", 32'(nib_o[0]), 32'd0);
        end
        check("nib_new_sel", 32'(sel_o[0]), 32'd2);
        check("nib_new", 32'(nib_o[0]), 32'hF);

        // Drop run during sel=4 SHOW, then restart
        wait_model(4, 2);
        run = 1'b0;
        tick();
        check("drop_en", 32'(en_o[0]), 32'd0);
        check("drop_sel", 32'(sel_o[0]), 32'd0);
        check("drop_fd", 32'(fd_o[0]), 32'd0);
        tick(); tick();
        run = 1'b1;
        tick();
        check("rerun_en", 32'(en_o[0]), 32'd1);
        check("rerun_sel", 32'(sel_o[0]), 32'd0);

        // Drop run exactly on the last digit's slot-end cycle
        wait_model(m_last[0], CLK_DIV - 1);
        run = 1'b0;
        tick();
        check("end_drop_fd0", 32'(fd_o[0]), 32'd0);
        check("end_drop_fd1", 32'(fd_o[1]), 32'd0);
        check("end_drop_en", 32'(en_o[0]), 32'd0);
        tick();
        check("end_drop_fd_late", 32'(fd_o[0]), 32'd0);
        check("end_drop_sel", 32'(sel_o[0]), 32'd0);

        // Reset pulse mid-BLANK
        run = 1'b1;
        tick();
        wait_model(-1, 6);
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrst_sel%0d", k), 32'(sel_o[k]), 32'd0);
            check($sformatf("midrst_en%0d", k), 32'(en_o[k]), 32'd0);
            check($sformatf("midrst_nib%0d", k), 32'(nib_o[k]), 32'd0);
            check($sformatf("midrst_fd%0d", k), 32'(fd_o[k]), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("postrst_en", 32'(en_o[0]), 32'd1);
        check("postrst_sel", 32'(sel_o[0]), 32'd0);

        // 64-cycle window: gapless enable never drops, gapped enable is 6 of 8
        lows = 0; highs = 0; changes = 0; prev = sel_o[1];
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!en_o[1]) lows++;
            if (en_o[0]) highs++;
            if (sel_o[1] != prev) changes++;
            prev = sel_o[1];
        end
        check("nogap_en_low", 32'(lows), 32'd0);
        check("nogap_sel_steps", 32'(changes), 32'd8);
        check("gap_en_high", 32'(highs), 32'd48);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            value = $urandom;
            if ($urandom_range(199, 0) == 0) run = ~run;
            if ($urandom_range(99, 0) == 0) num_digits = 3'($urandom_range(7, 0));
            rst_n = ($urandom_range(1499, 0) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
